// File: rtl/aba_pkg.sv
// ---------------------------------------------------------------------------
// aba_pkg -- shared definitions for the approximate borrow-chain subtractor.
//
// Contents:
//   WIDTH     : operand width (12, three 4-bit segments)
//   SEG_WIDTH : segment width (4)
//   seg_res_t : result of one 4-bit segment, {borrow, diff[3:0]}
// ---------------------------------------------------------------------------
package aba_pkg;

   localparam int WIDTH     = 12;
   localparam int SEG_WIDTH = 4;

   typedef struct packed {
      logic                 borrow;
      logic [SEG_WIDTH-1:0] diff;
   } seg_res_t;

endpackage : aba_pkg

// File: rtl/lsa4bit.sv
// ---------------------------------------------------------------------------
// lsa4bit -- 4-bit subtractor with lookahead borrow.
//
// Computes d = a - b - bin (mod 16) and the borrow out of bit 3.
//
// Ports:
//   bin  in   borrow into bit 0
//   a    in   minuend segment
//   b    in   subtrahend segment
//   d    out  difference segment
//   bout out  borrow out of bit 3 (1 when a < b + bin)
// ---------------------------------------------------------------------------
module lsa4bit (
   input  logic       bin,
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] d,
   output logic       bout
);

   // Bit i generates a borrow when a=0,b=1 and passes an incoming
   // borrow along when a==b.
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = ~a & b;
   assign p = ~(a ^ b);

   // Every borrow is flattened to two levels so no ripple path remains.
   assign c[0] = bin;
   assign c[1] = g[0] | (p[0] & bin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & bin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & bin);

   assign d    = a ^ b ^ c[3:0];
   assign bout = c[4];

endmodule : lsa4bit

// File: rtl/aba_sub_pipe.sv
// ---------------------------------------------------------------------------
// aba_sub_pipe -- two-stage, valid/ready pipelined 12-bit subtractor with an
// approximated low nibble.
//
// Default build: d[3:0] = {4{a[3]}}, borrow into bit 4 = ~a[3] & b[3].
// With macro ABA_SUB_EXACT_LSB_EN defined, the low nibble is subtracted
// exactly and the whole result is a - b (mod 4096).
//
// Stage 1 resolves the low and middle nibbles; stage 2 resolves the high
// nibble and drives the outputs. Latency 2, throughput 1/cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand pair valid
//   in_ready  out  operand pair accepted this cycle
//   in_a      in   minuend, unsigned
//   in_b      in   subtrahend, unsigned
//   out_valid out  result valid
//   out_ready in   downstream accepts the result
//   out_d     out  difference, modulo 2^WIDTH
//   out_bout  out  borrow out of bit WIDTH-1
// ---------------------------------------------------------------------------
module aba_sub_pipe #(
   parameter int WIDTH     = 12,
   parameter int SEG_WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_d,
   output logic             out_bout
);

   import aba_pkg::*;

   localparam int S = SEG_WIDTH;

   logic             s1_valid;
   logic             s1_load;
   logic             s2_load;
   logic [2*S-1:0]   s1_d_lo;
   logic             s1_borrow8;
   logic [S-1:0]     s1_a_hi;
   logic [S-1:0]     s1_b_hi;

   seg_res_t         seg_lo;
   seg_res_t         seg_mid;
   seg_res_t         seg_hi;

   // ---------------- handshake ----------------
   // in_ready depends only on state and out_ready, never on in_valid.
   assign s2_load  = ~out_valid | out_ready;
   assign s1_load  = ~s1_valid | s2_load;
   assign in_ready = s1_load;

   // ---------------- stage 1 datapath ----------------
`ifdef ABA_SUB_EXACT_LSB_EN
   lsa4bit u_lsa_lo (
      .bin  (1'b0),
      .a    (in_a[S-1:0]),
      .b    (in_b[S-1:0]),
      .d    (seg_lo.diff),
      .bout (seg_lo.borrow)
   );
`else
   // Low nibble approximated from bit 3 alone; bits [2:0] are ignored.
   assign seg_lo.diff   = {S{in_a[S-1]}};
   assign seg_lo.borrow = ~in_a[S-1] & in_b[S-1];

   logic unused_lsb;
   assign unused_lsb = ^{in_a[S-2:0], in_b[S-2:0]};
`endif

   lsa4bit u_lsa_mid (
      .bin  (seg_lo.borrow),
      .a    (in_a[2*S-1:S]),
      .b    (in_b[2*S-1:S]),
      .d    (seg_mid.diff),
      .bout (seg_mid.borrow)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
      end else if (s1_load) begin
         s1_valid <= in_valid;
      end
   end

   // NOTE: stage-1 data registers carry no reset; s1_valid qualifies them,
   // so whatever they hold after reset is never observed.
   always_ff @(posedge clk) begin
      if (s1_load && in_valid) begin
         s1_d_lo    <= {seg_mid.diff, seg_lo.diff};
         s1_borrow8 <= seg_mid.borrow;
         s1_a_hi    <= in_a[3*S-1:2*S];
         s1_b_hi    <= in_b[3*S-1:2*S];
      end
   end

   // ---------------- stage 2 datapath ----------------
   lsa4bit u_lsa_hi (
      .bin  (s1_borrow8),
      .a    (s1_a_hi),
      .b    (s1_b_hi),
      .d    (seg_hi.diff),
      .bout (seg_hi.borrow)
   );

   // Outputs only move when stage 2 loads, so a stalled result holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_d     <= '0;
         out_bout  <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_d    <= {seg_hi.diff, s1_d_lo};
            out_bout <= seg_hi.borrow;
         end
      end
   end

endmodule : aba_sub_pipe

// File: tb/tb_aba_sub_pipe.sv
// ---------------------------------------------------------------------------
// tb_aba_sub_pipe -- self-checking bench for aba_sub_pipe.
// Compile with or without ABA_SUB_EXACT_LSB_EN, matching the RTL build.
// ---------------------------------------------------------------------------
module tb_aba_sub_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] in_a;
   logic [11:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_d;
   logic        out_bout;

   int vectors     = 0;
   int miscompares = 0;
   int out_count   = 0;

   logic [12:0] exp_q[$];
   bit          prev_stall = 1'b0;
   logic [12:0] prev_out;

   aba_sub_pipe #(.WIDTH(12), .SEG_WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_d     (out_d),
      .out_bout  (out_bout)
   );

   always #5 clk = ~clk;

   // Reference: {borrow, difference} from whole-number arithmetic.
   function automatic logic [12:0] ref_sub(input logic [11:0] a, input logic [11:0] b);
      int          diff;
      int          hi;
      logic [31:0] dv;
      logic [12:0] r;
`ifdef ABA_SUB_EXACT_LSB_EN
      hi   = 0;
      diff = int'(a) - int'(b);
`else
      // Low nibble replaced by 0 or 15 according to a[3]; the upper eight
      // bits see a borrow only when a[3]=0 and b[3]=1.
      hi   = int'(a[11:4]) - int'(b[11:4]) - ((!a[3] && b[3]) ? 1 : 0);
      diff = hi * 16 + (a[3] ? 15 : 0);
`endif
      dv        = 32'(diff);
      r[12]     = (diff < 0);
      r[11:0]   = dv[11:0];
      return r;
   endfunction

   // One clock cycle: scoreboard transfers seen this cycle, then advance.
   task automatic cycle(output bit acc_in);
      bit acc_out;
      logic [12:0] exp;
      #1;
      if (prev_stall) begin
         vectors++;
         if (out_valid !== 1'b1 || {out_bout, out_d} !== prev_out) begin
            miscompares++;
            $display("FAIL hold: got v=%b %h, want v=1 %h", out_valid, {out_bout, out_d}, prev_out);
         end
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
         vectors++;
         out_count++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_out: got %h, want no result", {out_bout, out_d});
         end else begin
            exp = exp_q.pop_front();
            if ({out_bout, out_d} !== exp) begin
               miscompares++;
               $display("FAIL result: got bout=%b d=%h, want bout=%b d=%h",
                        out_bout, out_d, exp[12], exp[11:0]);
            end
         end
      end
      if (acc_in) exp_q.push_back(ref_sub(in_a, in_b));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_bout, out_d};
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      bit acc;
      int n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         cycle(acc);
         n++;
      end
      vectors++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_drain: %0d results still pending, want 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b, want 0", out_valid); end
      vectors++;
      if (out_d !== 12'h000) begin miscompares++; $display("FAIL rst_out_d: got %h, want 000", out_d); end
      vectors++;
      if (out_bout !== 1'b0) begin miscompares++; $display("FAIL rst_out_bout: got %b, want 0", out_bout); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b, want 1", in_ready); end
   endtask

   task automatic test_directed(input string name, input logic [11:0] a,
                                input logic [11:0] b, input logic [12:0] exp);
      bit acc;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      cycle(acc);
      in_valid  = 1'b0;
      vectors++;
      if (acc !== 1'b1) begin miscompares++; $display("FAIL %s_accept: got %b, want 1", name, acc); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s_early: got out_valid=%b, want 0", name, out_valid); end
      cycle(acc);
      vectors++;
      if (out_valid !== 1'b1 || {out_bout, out_d} !== exp) begin
         miscompares++;
         $display("FAIL %s: got v=%b bout=%b d=%h, want v=1 bout=%b d=%h",
                  name, out_valid, out_bout, out_d, exp[12], exp[11:0]);
      end
      drain(name);
   endtask

   task automatic test_back_to_back();
      bit acc;
      int sent  = 0;
      int cyc   = 0;
      int start = out_count;
      while (sent < 8 && cyc < 60) begin
         in_valid  = 1'b1;
         in_a      = 12'(32'h137 * (sent + 1) + 32'h0A5);
         in_b      = 12'(32'h2C9 * (sent + 3));
         out_ready = (cyc >= 5);
         #1;
         if (cyc == 2) begin
            vectors++;
            if (in_ready !== 1'b0 || sent != 2) begin
               miscompares++;
               $display("FAIL b2b_full: got in_ready=%b after %0d accepts, want 0 after 2", in_ready, sent);
            end
         end
         cycle(acc);
         if (acc) sent++;
         cyc++;
      end
      drain("b2b");
      vectors++;
      if (out_count - start != 8) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d results, want 8", out_count - start);
      end
   endtask

   task automatic test_reset_midflight();
      bit acc;
      int sent = 0;
      int n    = 0;
      out_ready = 1'b0;
      while (sent < 2 && n < 20) begin
         in_valid = 1'b1;
         in_a     = 12'($urandom);
         in_b     = 12'($urandom);
         cycle(acc);
         if (acc) sent++;
         n++;
      end
      in_valid = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_full: got out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || out_d !== 12'h000) begin
         miscompares++;
         $display("FAIL mid_rst: got out_valid=%b d=%h, want 0 000", out_valid, out_d);
      end
      exp_q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_in_ready: got %b, want 1", in_ready); end
      out_ready = 1'b1;
      repeat (5) begin
         vectors++;
         if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale: got out_valid=%b, want 0", out_valid); end
         cycle(acc);
      end
   endtask

   task automatic test_random();
      bit acc;
      for (int i = 0; i < 600; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_a      = 12'($urandom);
         in_b      = 12'($urandom);
         cycle(acc);
      end
      drain("rand");
   endtask

   initial begin
      test_reset();
`ifdef ABA_SUB_EXACT_LSB_EN
      test_directed("dir_100_001", 12'h100, 12'h001, {1'b0, 12'h0FF});
      test_directed("dir_000_010", 12'h000, 12'h010, {1'b1, 12'hFF0});
      test_directed("dir_5a8_123", 12'h5A8, 12'h123, {1'b0, 12'h485});
`else
      // a[3]=0 and b[3]=0: no borrow leaves the low nibble, giving 0x100.
      test_directed("dir_100_001", 12'h100, 12'h001, {1'b0, 12'h100});
      test_directed("dir_000_010", 12'h000, 12'h010, {1'b1, 12'hFF0});
      test_directed("dir_5a8_123", 12'h5A8, 12'h123, {1'b0, 12'h48F});
`endif
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_aba_sub_pipe
